// File: rtl/w0rm_mem_arb_pkg.sv
// Shared types and constants for the W0RM memory bus arbiter.
// Encodings are fixed so that state and port IDs match the core's debug views.
package w0rm_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic PORT_INST = 1'b0;
  localparam logic PORT_DATA = 1'b1;

endpackage

// File: rtl/w0rm_mem_arbiter_if.sv
// Bundle of the fetch, load/store and memory-bus handshake signals.
// The arbiter takes the slave view; the requesters and memory drive the master view.
interface w0rm_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  inst_valid_in;
  logic [ADDR_WIDTH-1:0] inst_addr_in;
  logic                  inst_ready_out;
  logic [DATA_WIDTH-1:0] inst_data_out;
  logic                  inst_data_valid_out;

  logic                  data_valid_in;
  logic [ADDR_WIDTH-1:0] data_addr_in;
  logic [DATA_WIDTH-1:0] data_wdata_in;
  logic                  data_we_in;
  logic                  data_ready_out;
  logic [DATA_WIDTH-1:0] data_rdata_out;
  logic                  data_rvalid_out;

  logic                  mem_valid_out;
  logic [ADDR_WIDTH-1:0] mem_addr_out;
  logic [DATA_WIDTH-1:0] mem_wdata_out;
  logic                  mem_we_out;
  logic                  mem_ready_in;
  logic                  mem_rvalid_in;
  logic [DATA_WIDTH-1:0] mem_rdata_in;

  modport slave (
    input  inst_valid_in, inst_addr_in,
    output inst_ready_out, inst_data_out, inst_data_valid_out,
    input  data_valid_in, data_addr_in, data_wdata_in, data_we_in,
    output data_ready_out, data_rdata_out, data_rvalid_out,
    output mem_valid_out, mem_addr_out, mem_wdata_out, mem_we_out,
    input  mem_ready_in, mem_rvalid_in, mem_rdata_in
  );

  modport master (
    output inst_valid_in, inst_addr_in,
    input  inst_ready_out, inst_data_out, inst_data_valid_out,
    output data_valid_in, data_addr_in, data_wdata_in, data_we_in,
    input  data_ready_out, data_rdata_out, data_rvalid_out,
    input  mem_valid_out, mem_addr_out, mem_wdata_out, mem_we_out,
    output mem_ready_in, mem_rvalid_in, mem_rdata_in
  );
endinterface

// File: rtl/w0rm_rr_arb2.sv
// Combinational two-way round-robin pick: on a tie the port that did not win last time wins.
module w0rm_rr_arb2
  import w0rm_mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_id
);

  always_comb begin
    gnt_valid = |req;
    gnt_id    = PORT_INST;
    if (req == 2'b11)
      gnt_id = ~last;
    else if (req[PORT_DATA])
      gnt_id = PORT_DATA;
  end

endmodule

// File: rtl/w0rm_mem_arbiter.sv
// Shares the single memory bus between instruction fetch and the memory unit,
// one outstanding transaction at a time, responses routed back to the owner.
module w0rm_mem_arbiter
  import w0rm_mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  w0rm_mem_arbiter_if.slave   bus,
  output logic                busy_out,
  output logic                grant_out,
  output logic                error_out
);

  state_t                state_q, state_d;
  logic                  last_q, grant_q, err_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] idata_q, drdata_q;
  logic                  ivld_q, dvld_q;
  logic                  gnt_valid, gnt_id, accept;

  w0rm_rr_arb2 u_rr (
    .req       ({bus.data_valid_in, bus.inst_valid_in}),
    .last      (last_q),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: if (gnt_valid) begin
        accept  = 1'b1;
        state_d = ISSUE;
      end
      ISSUE: if (bus.mem_ready_in) state_d = WAIT;
      WAIT:  if (bus.mem_rvalid_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      last_q   <= PORT_DATA;
      grant_q  <= PORT_INST;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      idata_q  <= '0;
      drdata_q <= '0;
      ivld_q   <= 1'b0;
      dvld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ivld_q  <= 1'b0;
      dvld_q  <= 1'b0;
      if (accept) begin
        grant_q <= gnt_id;
        last_q  <= gnt_id;
        addr_q  <= (gnt_id == PORT_DATA) ? bus.data_addr_in : bus.inst_addr_in;
        wdata_q <= (gnt_id == PORT_DATA) ? bus.data_wdata_in : '0;
        we_q    <= (gnt_id == PORT_DATA) & bus.data_we_in;
      end
      // A response only counts while waiting for one; anything else is a bus protocol error.
      if (bus.mem_rvalid_in) begin
        if (state_q == WAIT) begin
          if (grant_q == PORT_DATA) begin
            drdata_q <= bus.mem_rdata_in;
            dvld_q   <= 1'b1;
          end else begin
            idata_q <= bus.mem_rdata_in;
            ivld_q  <= 1'b1;
          end
        end else begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign bus.inst_ready_out      = accept & (gnt_id == PORT_INST);
  assign bus.data_ready_out      = accept & (gnt_id == PORT_DATA);
  assign bus.inst_data_out       = idata_q;
  assign bus.inst_data_valid_out = ivld_q;
  assign bus.data_rdata_out      = drdata_q;
  assign bus.data_rvalid_out     = dvld_q;
  assign bus.mem_valid_out       = (state_q == ISSUE);
  assign bus.mem_addr_out        = addr_q;
  assign bus.mem_wdata_out       = wdata_q;
  assign bus.mem_we_out          = we_q;
  assign busy_out                = (state_q != IDLE);
  assign grant_out               = grant_q;
  assign error_out               = err_q;

endmodule

// File: tb/tb_w0rm_mem_arbiter.sv
// Directed bench for w0rm_mem_arbiter: fetch, tie alternation, backpressure,
// spurious responses, reset mid-transaction and zero-latency memory.
module tb_w0rm_mem_arbiter;

  logic clk = 1'b0;
  logic reset;
  logic busy_out, grant_out, error_out;
  int   checks = 0;
  int   failures = 0;

  w0rm_mem_arbiter_if bus ();

  w0rm_mem_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .busy_out  (busy_out),
    .grant_out (grant_out),
    .error_out (error_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.inst_valid_in = 1'b0; bus.inst_addr_in = '0;
    bus.data_valid_in = 1'b0; bus.data_addr_in = '0;
    bus.data_wdata_in = '0;   bus.data_we_in   = 1'b0;
    bus.mem_ready_in  = 1'b0; bus.mem_rvalid_in = 1'b0; bus.mem_rdata_in = '0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    chk("rst_busy", busy_out, 0);
    chk("rst_grant", grant_out, 0);
    chk("rst_error", error_out, 0);
    chk("rst_mem_valid", bus.mem_valid_out, 0);
    chk("rst_mem_addr", bus.mem_addr_out, 0);
    chk("rst_inst_dv", bus.inst_data_valid_out, 0);
    chk("rst_data_rv", bus.data_rvalid_out, 0);

    // Single fetch
    bus.inst_valid_in = 1'b1; bus.inst_addr_in = 32'h100; bus.mem_ready_in = 1'b1;
    #1;
    chk("f_inst_ready", bus.inst_ready_out, 1);
    chk("f_data_ready", bus.data_ready_out, 0);
    tick();
    bus.inst_valid_in = 1'b0;
    chk("f_mem_valid", bus.mem_valid_out, 1);
    chk("f_mem_addr", bus.mem_addr_out, 32'h100);
    chk("f_mem_we", bus.mem_we_out, 0);
    chk("f_busy", busy_out, 1);
    chk("f_grant", grant_out, 0);
    tick();
    chk("f_wait_mem_valid", bus.mem_valid_out, 0);
    chk("f_wait_busy", busy_out, 1);
    bus.mem_rvalid_in = 1'b1; bus.mem_rdata_in = 32'hDEADBEEF;
    tick();
    bus.mem_rvalid_in = 1'b0;
    chk("f_inst_dv", bus.inst_data_valid_out, 1);
    chk("f_inst_data", bus.inst_data_out, 32'hDEADBEEF);
    chk("f_data_rv", bus.data_rvalid_out, 0);
    chk("f_idle", busy_out, 0);
    tick();
    chk("f_inst_dv_drop", bus.inst_data_valid_out, 0);
    chk("f_inst_data_hold", bus.inst_data_out, 32'hDEADBEEF);
    chk("f_no_error", error_out, 0);

    // Tie after reset: inst, data, inst
    do_reset();
    bus.inst_valid_in = 1'b1; bus.inst_addr_in = 32'h10;
    bus.data_valid_in = 1'b1; bus.data_addr_in = 32'h20;
    bus.data_wdata_in = 32'h55; bus.data_we_in = 1'b1;
    bus.mem_ready_in  = 1'b1;
    #1;
    chk("t1_inst_ready", bus.inst_ready_out, 1);
    chk("t1_data_ready", bus.data_ready_out, 0);
    tick();
    chk("t1_addr", bus.mem_addr_out, 32'h10);
    chk("t1_we", bus.mem_we_out, 0);
    chk("t1_grant", grant_out, 0);
    chk("t1_data_ready_busy", bus.data_ready_out, 0);
    tick();
    bus.mem_rvalid_in = 1'b1; bus.mem_rdata_in = 32'hA1;
    tick();
    bus.mem_rvalid_in = 1'b0;
    #1;
    chk("t1_inst_dv", bus.inst_data_valid_out, 1);
    chk("t2_data_ready", bus.data_ready_out, 1);
    chk("t2_inst_ready", bus.inst_ready_out, 0);
    tick();
    chk("t2_addr", bus.mem_addr_out, 32'h20);
    chk("t2_we", bus.mem_we_out, 1);
    chk("t2_wdata", bus.mem_wdata_out, 32'h55);
    chk("t2_grant", grant_out, 1);
    tick();
    bus.mem_rvalid_in = 1'b1; bus.mem_rdata_in = 32'hB2;
    tick();
    bus.mem_rvalid_in = 1'b0;
    #1;
    chk("t2_data_rv", bus.data_rvalid_out, 1);
    chk("t2_inst_dv", bus.inst_data_valid_out, 0);
    chk("t2_inst_data_hold", bus.inst_data_out, 32'hA1);
    chk("t3_inst_ready", bus.inst_ready_out, 1);
    tick();
    bus.inst_valid_in = 1'b0; bus.data_valid_in = 1'b0; bus.data_we_in = 1'b0;
    chk("t3_addr", bus.mem_addr_out, 32'h10);
    chk("t3_grant", grant_out, 0);
    tick();
    bus.mem_rvalid_in = 1'b1; bus.mem_rdata_in = 32'hC3;
    tick();
    bus.mem_rvalid_in = 1'b0;
    chk("t3_inst_dv", bus.inst_data_valid_out, 1);
    chk("t3_inst_data", bus.inst_data_out, 32'hC3);
    chk("t3_data_rdata_hold", bus.data_rdata_out, 32'hB2);

    // Bus backpressure: mem_ready low for 4 cycles
    bus.mem_ready_in = 1'b0;
    bus.data_valid_in = 1'b1; bus.data_addr_in = 32'h300; bus.data_we_in = 1'b0;
    #1;
    chk("b_data_ready", bus.data_ready_out, 1);
    tick();
    bus.data_valid_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        bus.data_valid_in = 1'b1; bus.data_addr_in = 32'h304;
      end
      #1;
      chk("b_mem_valid", bus.mem_valid_out, 1);
      chk("b_addr_stable", bus.mem_addr_out, 32'h300);
      chk("b_we_stable", bus.mem_we_out, 0);
      chk("b_no_accept", bus.data_ready_out, 0);
      tick();
    end
    bus.mem_ready_in = 1'b1;
    #1;
    chk("b_mem_valid_5th", bus.mem_valid_out, 1);
    chk("b_addr_5th", bus.mem_addr_out, 32'h300);
    tick();
    chk("b_wait_mem_valid", bus.mem_valid_out, 0);
    chk("b_wait_no_accept", bus.data_ready_out, 0);
    bus.mem_rvalid_in = 1'b1; bus.mem_rdata_in = 32'h77;
    tick();
    bus.mem_rvalid_in = 1'b0;
    #1;
    chk("b_data_rv", bus.data_rvalid_out, 1);
    chk("b_data_rdata", bus.data_rdata_out, 32'h77);
    chk("b_next_accept", bus.data_ready_out, 1);
    tick();
    bus.data_valid_in = 1'b0;
    chk("b2_addr", bus.mem_addr_out, 32'h304);
    tick();
    bus.mem_rvalid_in = 1'b1; bus.mem_rdata_in = 32'h88;
    tick();
    bus.mem_rvalid_in = 1'b0;
    chk("b2_data_rv", bus.data_rvalid_out, 1);
    chk("b2_data_rdata", bus.data_rdata_out, 32'h88);
    chk("b_no_error", error_out, 0);

    // Spurious response while idle
    tick();
    bus.mem_rvalid_in = 1'b1; bus.mem_rdata_in = 32'h99;
    tick();
    bus.mem_rvalid_in = 1'b0;
    chk("s_error", error_out, 1);
    chk("s_inst_dv", bus.inst_data_valid_out, 0);
    chk("s_data_rv", bus.data_rvalid_out, 0);
    chk("s_busy", busy_out, 0);
    tick();
    tick();
    chk("s_error_sticky", error_out, 1);
    do_reset();
    chk("s_error_cleared", error_out, 0);

    // Reset while waiting for a data-port response
    bus.data_valid_in = 1'b1; bus.data_addr_in = 32'h400; bus.data_we_in = 1'b0;
    bus.mem_ready_in = 1'b1;
    tick();
    bus.data_valid_in = 1'b0;
    tick();
    chk("r_busy_wait", busy_out, 1);
    chk("r_grant_data", grant_out, 1);
    do_reset();
    chk("r_busy", busy_out, 0);
    chk("r_grant", grant_out, 0);
    chk("r_error", error_out, 0);
    chk("r_mem_valid", bus.mem_valid_out, 0);
    chk("r_mem_addr", bus.mem_addr_out, 0);
    chk("r_data_rdata", bus.data_rdata_out, 0);
    bus.mem_rvalid_in = 1'b1; bus.mem_rdata_in = 32'h1234;
    tick();
    bus.mem_rvalid_in = 1'b0;
    chk("r_late_error", error_out, 1);
    chk("r_late_data_rv", bus.data_rvalid_out, 0);
    chk("r_late_inst_dv", bus.inst_data_valid_out, 0);
    chk("r_late_rdata", bus.data_rdata_out, 0);

    // Zero-latency memory, continuous fetches: one pulse every 3 cycles
    do_reset();
    bus.inst_valid_in = 1'b1; bus.inst_addr_in = 32'h500; bus.mem_ready_in = 1'b1;
    for (int n = 0; n < 9; n++) begin
      bus.mem_rvalid_in = (n % 3 == 2);
      bus.mem_rdata_in  = 32'h1000 + n;
      #1;
      chk("z_inst_ready", bus.inst_ready_out, (n % 3 == 0));
      tick();
      chk("z_inst_dv", bus.inst_data_valid_out, (n % 3 == 2));
      if (n % 3 == 2) chk("z_inst_data", bus.inst_data_out, 32'h1000 + n);
    end
    bus.inst_valid_in = 1'b0; bus.mem_rvalid_in = 1'b0;
    chk("z_no_error", error_out, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/w0rm_mem_arbiter.md
# w0rm_mem_arbiter

Two-port arbiter sharing the W0RM core's single memory bus between the instruction-fetch unit (read-only) and the memory unit (load/store). It accepts one request at a time with 2-way round-robin priority, drives it onto the memory bus with a valid/ready handshake, waits for the response and routes it back to the owning requester. At most one transaction is outstanding, which gives deterministic ordering for IFetch and MemUnit verification.

## Interface
- `ADDR_WIDTH`, 32: address width on all ports.
- `DATA_WIDTH`, 32: data width on all ports.

Clock and reset: one clock; reset is synchronous and active-high.

- `clk` in 1: core clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `inst_valid_in` in 1: instruction fetch request.
- `inst_addr_in` in ADDR_WIDTH: fetch address.
- `inst_ready_out` out 1: fetch request accepted this cycle.
- `inst_data_out` out DATA_WIDTH: fetched word.
- `inst_data_valid_out` out 1: one-cycle pulse; `inst_data_out` is valid.
- `data_valid_in` in 1: load/store request.
- `data_addr_in` in ADDR_WIDTH: load/store address.
- `data_wdata_in` in DATA_WIDTH: store data.
- `data_we_in` in 1: 1 = store, 0 = load.
- `data_ready_out` out 1: load/store request accepted this cycle.
- `data_rdata_out` out DATA_WIDTH: load data.
- `data_rvalid_out` out 1: one-cycle completion pulse for both loads and stores.
- `mem_valid_out` out 1: bus request.
- `mem_addr_out` out ADDR_WIDTH: bus address.
- `mem_wdata_out` out DATA_WIDTH: bus write data.
- `mem_we_out` out 1: bus write enable.
- `mem_ready_in` in 1: bus accepted the request.
- `mem_rvalid_in` in 1: bus response or write acknowledge.
- `mem_rdata_in` in DATA_WIDTH: bus read data.
- `busy_out` out 1: state is not IDLE.
- `grant_out` out 1: owner of the current or last transaction; 0 = inst, 1 = data.
- `error_out` out 1: sticky; set on a `mem_rvalid_in` outside WAIT.

## Operation
- State machine has three states: IDLE, ISSUE and WAIT.
- **IDLE**, no request valid: state stays IDLE.
- **IDLE**, one request valid: that port wins. The arbiter asserts its `*_ready_out` combinationally, latches address, write data and write enable into the bus registers, sets `grant_out`, and moves to ISSUE.
- **IDLE**, both requests valid: the port that is not `last_grant` wins. `last_grant` is updated to the winner.
- **ISSUE**: `mem_valid_out` = 1 with the latched fields held stable. When `mem_ready_in` = 1, `mem_valid_out` drops next cycle and state moves to WAIT.
- **WAIT**: on `mem_rvalid_in` = 1, `mem_rdata_in` is registered into the owner's data output. The owner's valid pulse is high for exactly the next cycle, and state returns to IDLE in that same cycle.
- For stores, `data_rdata_out` takes `mem_rdata_in` but its value is don't-care; the pulse is the completion.
- The non-owner's data and valid outputs hold their values; its valid stays 0.
- A `mem_rvalid_in` seen in IDLE or ISSUE is ignored and sets `error_out`. Only reset clears `error_out`.
- A requester must hold `*_valid_in` and its fields until `*_ready_out`. The arbiter never accepts on a cycle where it is not in IDLE.

## Timing
- **Reset** takes priority over all events, including mid-transaction. Reset values:
  - state = IDLE, `last_grant` = data (so inst wins the first tie).
  - All `*_valid_out`, `*_ready_out`, `busy_out`, `grant_out` and `error_out` = 0.
  - All data and address outputs = 0.
  - A bus response arriving after reset lands in IDLE and sets `error_out`.
- **Accept to issue**: request accepted in cycle 0 puts `mem_valid_out` = 1 in cycle 1.
- **Issue to wait**: with `mem_ready_in` = 1 in cycle 1, state is WAIT in cycle 2.
- **Response to pulse**: `mem_rvalid_in` in cycle k gives the owner's valid pulse in cycle k+1, IDLE in cycle k+1, and the next accept possible in cycle k+1.
- **Minimum turnaround**: 3 cycles per transaction (accept, issue, response at k = 2).
- `mem_rvalid_in` in the same cycle as the ISSUE handshake is not a valid response: it is ignored and flags `error_out`.
- Back-to-back tie requests alternate strictly: inst, data, inst, and so on.

## Structure
- Shared package `w0rm_mem_arb_pkg` holds:
  - State encoding localparams: IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2.
  - Port IDs: PORT_INST = 1'b0, PORT_DATA = 1'b1.
- Sub-module `w0rm_rr_arb2`: combinational 2-way round-robin pick.
  - Inputs: `req[1:0]`, `last`.
  - Outputs: `gnt_valid`, `gnt_id`.
- FSM, bus registers and response routing live in the top module.

## Test plan
- **Single fetch**: `inst_addr_in` = 0x100 with memory returning 0xDEADBEEF and `mem_ready_in` held 1. Required: `mem_valid_out` in cycle 1 with `mem_addr_out` = 0x100 and `mem_we_out` = 0; `inst_data_valid_out` pulses 1 cycle with `inst_data_out` = 0xDEADBEEF; `data_rvalid_out` stays 0.
- **Tie after reset**: both ports request (inst 0x10; data store 0x20/0x55) and stay asserted. Required: grants go inst, then data (`mem_we_out` = 1, `mem_wdata_out` = 0x55), then inst; `grant_out` follows 0, 1, 0.
- **Bus backpressure**: `mem_ready_in` low for 4 cycles. Required: `mem_valid_out` held 5 cycles with fields stable; `data_ready_out` stays 0 for a newly arriving data request until IDLE.
- **Spurious response**: `mem_rvalid_in` pulsed while IDLE. Required: `error_out` goes to 1 and stays 1; no valid pulse on either port; reset clears `error_out`.
- **Reset in WAIT**: assert reset while in WAIT, then deliver `mem_rvalid_in`. Required: all outputs 0 after reset; the late response sets `error_out` and produces no valid pulse.
- **Zero-latency memory**: `mem_rvalid_in` asserted on the first WAIT cycle, continuous fetches. Required: one `inst_data_valid_out` pulse every 3 cycles.
